// File: rtl/bnn_sched_pkg.sv
// Shared encodings and default sizing for the ECG BNN layer scheduler.
package bnn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int unsigned NUM_LAYERS_DEF = 7;
  localparam int unsigned CLASS_W_DEF    = 5;
  localparam int unsigned LIDX_W_DEF     = 3;

  // Wide all-ones pattern; users slice it to their class width.
  localparam logic [31:0] CLASS_TIMEOUT = '1;

endpackage

// File: rtl/bnn_sched_watchdog.sv
// Per-layer WAIT cycle counter with terminal-count flag.
// Only instantiated when BNN_SCHED_WATCHDOG_EN is defined.
module bnn_sched_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero outside WAIT, so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst || !in_wait) begin
      cnt <= '0;
    end else if (cnt != TERM) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = in_wait && (cnt == TERM);

endmodule

// File: rtl/bnn_layer_scheduler.sv
// Top-level layer sequencer: edge-triggered run, start/done handshake per layer,
// ping-pong buffer select. Optional per-layer watchdog: BNN_SCHED_WATCHDOG_EN.
module bnn_layer_scheduler
  import bnn_sched_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = NUM_LAYERS_DEF,
  parameter int unsigned CLASS_W     = CLASS_W_DEF,
  parameter int unsigned LIDX_W      = LIDX_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ecg_rd_done,
  output logic               layer_start,
  output logic [LIDX_W-1:0]  layer_idx,
  output logic               buf_sel,
  input  logic               layer_done,
  input  logic [CLASS_W-1:0] class_in,
  output logic               busy,
  output logic               done,
  output logic [CLASS_W-1:0] classout,
  output logic               timeout_err
);

  localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LAYERS - 1);

  if (NUM_LAYERS < 1 || (64'd1 << LIDX_W) < 64'(NUM_LAYERS)) begin : g_bad_layers
    $error("bnn_layer_scheduler: NUM_LAYERS must be >= 1 and fit in LIDX_W bits");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("bnn_layer_scheduler: TIMEOUT_CYC must be >= 2");
  end

  state_t state;
  logic   ecg_hist;
  logic   trigger;

  assign trigger     = ecg_rd_done && !ecg_hist;
  assign layer_start = (state == LAUNCH);

`ifdef BNN_SCHED_WATCHDOG_EN
  logic wd_expired;

  bnn_sched_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .in_wait (state == WAIT),
    .expired (wd_expired)
  );
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ecg_hist  <= 1'b0;
      layer_idx <= '0;
      buf_sel   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      classout  <= '0;
`ifdef BNN_SCHED_WATCHDOG_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      ecg_hist <= ecg_rd_done;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state     <= LAUNCH;
            busy      <= 1'b1;
            done      <= 1'b0;
            layer_idx <= '0;
            buf_sel   <= 1'b0;
`ifdef BNN_SCHED_WATCHDOG_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          // layer_done takes priority over a watchdog expiry on the same cycle.
          if (layer_done) begin
            if (layer_idx == LAST_IDX) begin
              state <= FINISH;
            end else begin
              layer_idx <= layer_idx + LIDX_W'(1);
              buf_sel   <= ~buf_sel;
              state     <= LAUNCH;
            end
          end
`ifdef BNN_SCHED_WATCHDOG_EN
          else if (wd_expired) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            classout    <= CLASS_TIMEOUT[CLASS_W-1:0];
            state       <= IDLE;
          end
`endif
        end
        FINISH: begin
          classout <= class_in;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// Directed scoreboard bench for bnn_layer_scheduler (default and 1-layer configs).
module tb_bnn_layer_scheduler;

  localparam int unsigned NL = 7;
  localparam int unsigned CW = 5;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ecg_rd_done;
  logic          layer_done;
  logic [CW-1:0] class_in;
  logic          layer_start;
  logic [LW-1:0] layer_idx;
  logic          buf_sel;
  logic          busy;
  logic          done;
  logic [CW-1:0] classout;
  logic          timeout_err;

  logic          m_ecg;
  logic          m_ldone;
  logic [CW-1:0] m_cls_in;
  logic          m_start;
  logic [0:0]    m_idx;
  logic          m_bsel;
  logic          m_busy;
  logic          m_done;
  logic [CW-1:0] m_cls;
  logic          m_to;

  bnn_layer_scheduler #(
    .NUM_LAYERS  (NL),
    .CLASS_W     (CW),
    .LIDX_W      (LW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ecg_rd_done (ecg_rd_done),
    .layer_start (layer_start),
    .layer_idx   (layer_idx),
    .buf_sel     (buf_sel),
    .layer_done  (layer_done),
    .class_in    (class_in),
    .busy        (busy),
    .done        (done),
    .classout    (classout),
    .timeout_err (timeout_err)
  );

  bnn_layer_scheduler #(
    .NUM_LAYERS  (1),
    .CLASS_W     (CW),
    .LIDX_W      (1),
    .TIMEOUT_CYC (16)
  ) dut_min (
    .clk         (clk),
    .rst         (rst),
    .ecg_rd_done (m_ecg),
    .layer_start (m_start),
    .layer_idx   (m_idx),
    .buf_sel     (m_bsel),
    .layer_done  (m_ldone),
    .class_in    (m_cls_in),
    .busy        (m_busy),
    .done        (m_done),
    .classout    (m_cls),
    .timeout_err (m_to)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nstarts = 0;
  int m_nstarts = 0;
  int base;

  typedef struct packed {
    logic [LW-1:0] idx;
    logic          bsel;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] cls_q[$];
  logic [CW-1:0] m_cls_q[$];

  always @(posedge clk) begin
    if (!rst && layer_start) nstarts++;
    if (!rst && m_start) m_nstarts++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [CW-1:0] cls);
    for (int unsigned i = 0; i < NL; i++) begin
      exp_t e;
      e.idx  = LW'(i);
      e.bsel = i[0];
      exp_q.push_back(e);
    end
    cls_q.push_back(cls);
  endtask

  // Engine model: answers one layer_start with layer_done after lat cycles.
  task automatic serve(input int lat, input bit spur, input bit toggle);
    exp_t          e;
    bit            ok;
    bit            last;
    logic [CW-1:0] c;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (layer_start) ok = 1'b1;
      else step();
    end
    check("start_seen", 32'(ok), 32'd1);
    if (!ok) return;
    e    = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    last = (e.idx == LW'(NL - 1));
    check("layer_idx", 32'(layer_idx), 32'(e.idx));
    check("buf_sel", 32'(buf_sel), 32'(e.bsel));
    check("busy_run", 32'(busy), 32'd1);
    if (spur) layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    check("start_pulse_width", 32'(layer_start), 32'd0);
    if (spur) check("spur_launch_idx", 32'(layer_idx), 32'(e.idx));
    if (toggle) begin
      ecg_rd_done = 1'b0;
      step();
      ecg_rd_done = 1'b1;
      repeat (lat - 2) step();
    end else begin
      repeat (lat - 1) step();
    end
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    if (last) begin
      check("finish_done_low", 32'(done), 32'd0);
      step();
      c = (cls_q.size() > 0) ? cls_q.pop_front() : 'x;
      check("done", 32'(done), 32'd1);
      check("classout", 32'(classout), 32'(c));
      check("busy_end", 32'(busy), 32'd0);
      check("timeout_err_end", 32'(timeout_err), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(layer_start), 32'd0);
    check({tag, "_idx"}, 32'(layer_idx), 32'd0);
    check({tag, "_bsel"}, 32'(buf_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_classout"}, 32'(classout), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [CW-1:0] mc;
    rst = 1'b1; ecg_rd_done = 1'b0; layer_done = 1'b0; class_in = '0;
    m_ecg = 1'b0; m_ldone = 1'b0; m_cls_in = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Nominal run with a spurious done in LAUNCH and a retrigger mid-run.
    class_in = 5'd3;
    push_run(5'd3);
    base = nstarts;
    ecg_rd_done = 1'b1;
    for (int i = 0; i < int'(NL); i++) serve(3, i == 1, i == 3);
    check("nominal_starts", 32'(nstarts - base), 32'd7);

    repeat (10) step();
    check("hold_high_no_run", 32'(nstarts - base), 32'd7);
    check("done_held", 32'(done), 32'd1);

    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    step();
    check("idle_spur_idx", 32'(layer_idx), 32'd6);
    check("idle_spur_start", 32'(layer_start), 32'd0);
    check("idle_spur_done", 32'(done), 32'd1);
    check("idle_spur_busy", 32'(busy), 32'd0);

    // Fresh low-to-high trigger after done.
    ecg_rd_done = 1'b0;
    step();
    class_in = 5'd9;
    push_run(5'd9);
    ecg_rd_done = 1'b1;
    base = nstarts;
    step();
    check("retrig_busy", 32'(busy), 32'd1);
    check("retrig_done_clr", 32'(done), 32'd0);
    for (int i = 0; i < int'(NL); i++) serve(3, 1'b0, 1'b0);
    check("retrig_starts", 32'(nstarts - base), 32'd7);

    // Reset during layer 4's WAIT, then restart from ecg_rd_done held high.
    ecg_rd_done = 1'b0;
    step();
    class_in = 5'd21;
    push_run(5'd21);
    ecg_rd_done = 1'b1;
    for (int i = 0; i < 4; i++) serve(3, 1'b0, 1'b0);
    step();
    step();
    check("l4_wait_idx", 32'(layer_idx), 32'd4);
    rst = 1'b1;
    step();
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    cls_q.delete();
    push_run(5'd21);
    rst = 1'b0;
    step();
    for (int i = 0; i < int'(NL); i++) serve(3, 1'b0, 1'b0);

`ifdef BNN_SCHED_WATCHDOG_EN
    ecg_rd_done = 1'b0;
    step();
    class_in = 5'd5;
    push_run(5'd5);
    ecg_rd_done = 1'b1;
    serve(3, 1'b0, 1'b0);
    serve(3, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !layer_start; i++) step();
    check("wd_layer2_idx", 32'(layer_idx), 32'd2);
    step();
    repeat (15) step();
    check("wd_pre_timeout", 32'(timeout_err), 32'd0);
    check("wd_pre_busy", 32'(busy), 32'd1);
    step();
    check("wd_timeout_err", 32'(timeout_err), 32'd1);
    check("wd_done", 32'(done), 32'd1);
    check("wd_classout", 32'(classout), 32'h1F);
    check("wd_busy", 32'(busy), 32'd0);
    base = nstarts;
    repeat (5) step();
    check("wd_idle_no_start", 32'(nstarts - base), 32'd0);
    exp_q.delete();
    cls_q.delete();

    ecg_rd_done = 1'b0;
    step();
    class_in = 5'd6;
    push_run(5'd6);
    ecg_rd_done = 1'b1;
    step();
    check("wd_err_cleared", 32'(timeout_err), 32'd0);
    serve(3, 1'b0, 1'b0);
    serve(16, 1'b0, 1'b0);
    check("wd_limit_no_err", 32'(timeout_err), 32'd0);
    for (int i = 2; i < int'(NL); i++) serve(3, 1'b0, 1'b0);
`endif

    // Single-layer configuration.
    m_cls_q.push_back(5'd17);
    m_cls_in = 5'd17;
    m_ecg = 1'b1;
    step();
    check("min_start", 32'(m_start), 32'd1);
    check("min_idx", 32'(m_idx), 32'd0);
    check("min_bsel", 32'(m_bsel), 32'd0);
    step();
    check("min_start_width", 32'(m_start), 32'd0);
    step();
    m_ldone = 1'b1;
    step();
    m_ldone = 1'b0;
    check("min_finish_done_low", 32'(m_done), 32'd0);
    step();
    mc = (m_cls_q.size() > 0) ? m_cls_q.pop_front() : 'x;
    check("min_done", 32'(m_done), 32'd1);
    check("min_classout", 32'(m_cls), 32'(mc));
    check("min_busy", 32'(m_busy), 32'd0);
    check("min_bsel_end", 32'(m_bsel), 32'd0);
    check("min_timeout", 32'(m_to), 32'd0);
    repeat (5) step();
    check("min_single_start", 32'(m_nstarts), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
